// File: rtl/spi_prog_pkg.sv
// Shared opcodes, FSM state encoding and STATUS byte layout for the SPI programming port.
package spi_prog_pkg;

  localparam logic [7:0] OP_SET_ADDR = 8'hC0;
  localparam logic [7:0] OP_WRITE    = 8'hC1;
  localparam logic [7:0] OP_READ     = 8'hC2;
  localparam logic [7:0] OP_ECHO     = 8'hC3;
  localparam logic [7:0] OP_RUN      = 8'hC4;
  localparam logic [7:0] OP_HALT     = 8'hC5;
  localparam logic [7:0] OP_STATUS   = 8'hC6;

  localparam int STATUS_ERR_BIT = 7;
  localparam int STATUS_RUN_BIT = 6;

  typedef enum logic [2:0] {
    ST_IDLE, ST_OPCODE, ST_ADDR, ST_WRITE, ST_READ, ST_ECHO, ST_STATUS, ST_DRAIN
  } state_t;

  function automatic logic [7:0] status_byte(input logic err, input logic run);
    logic [7:0] b;
    b                 = '0;
    b[STATUS_ERR_BIT] = err;
    b[STATUS_RUN_BIT] = run;
    return b;
  endfunction

endpackage

// File: rtl/spi_byte_phy.sv
// SPI mode-0 byte PHY: synchronises sclk/cs/mosi into clk, detects sclk edges,
// assembles received bytes and shifts a loaded transmit byte out on miso.
module spi_byte_phy #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sclk,
  input  logic       i_cs,
  input  logic       i_mosi,
  input  logic       i_tx_load,
  input  logic [7:0] i_tx_byte,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_cs_active,
  output logic       o_miso
);

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_d;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_rx_shift;
  logic [7:0]             r_tx_shift;
  logic                   w_sclk_s, w_mosi_s, w_rise, w_fall;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign o_cs_active = ~r_cs_sync[SYNC_STAGES-1];
  assign w_rise      = w_sclk_s & ~r_sclk_d;
  assign w_fall      = ~w_sclk_s & r_sclk_d;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sclk_d    <= w_sclk_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
    end else if (!o_cs_active) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
    end else begin
      if (w_rise) begin
        r_rx_shift <= {r_rx_shift[5:0], w_mosi_s};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end
      // The fall after the 8th rise must not shift, or the freshly loaded MSB is lost.
      if (i_tx_load)
        r_tx_shift <= i_tx_byte;
      else if (w_fall && r_bit_cnt != 3'd0)
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
    end
  end

  assign o_rx_valid = o_cs_active & w_rise & (r_bit_cnt == 3'd7);
  assign o_rx_byte  = {r_rx_shift, w_mosi_s};
  assign o_miso     = r_tx_shift[7];

endmodule

// File: rtl/spi_prog_loader.sv
// SPI-slave imem programming port: SET_ADDR/WRITE/ECHO/RUN/HALT/STATUS, plus burst
// READ when SPI_PROG_READBACK_EN is defined (otherwise C2 is an illegal opcode).
module spi_prog_loader
  import spi_prog_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  cmd_error
);

  localparam int         NB             = DATA_WIDTH / 8;
  localparam int         ADDR_BYTES     = (ADDR_WIDTH + 7) / 8;
  localparam logic [3:0] LAST_BYTE      = 4'(NB - 1);
  localparam logic [3:0] LAST_ADDR_BYTE = 4'(ADDR_BYTES - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr, r_addr_acc, w_addr_next;
  logic [3:0]            r_byte_cnt;
  logic [DATA_WIDTH-1:0] r_wr_shift, r_mem_wr_data, w_wr_next;
  logic                  r_tx_load, r_mem_wr_en, r_mem_rd_en, r_cpu_run, r_cmd_error;
  logic [7:0]            r_tx_byte, w_rx_byte;
  logic                  w_rx_valid, w_cs_active;

  spi_byte_phy #(.SYNC_STAGES(SYNC_STAGES)) u_phy (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sclk     (sclk),
    .i_cs       (cs),
    .i_mosi     (mosi),
    .i_tx_load  (r_tx_load),
    .i_tx_byte  (r_tx_byte),
    .o_rx_byte  (w_rx_byte),
    .o_rx_valid (w_rx_valid),
    .o_cs_active(w_cs_active),
    .o_miso     (miso)
  );

  // Shifting MSB-first and truncating keeps only the low bits of the accumulated value.
  assign w_wr_next   = DATA_WIDTH'({r_wr_shift, w_rx_byte});
  assign w_addr_next = ADDR_WIDTH'({r_addr_acc, w_rx_byte});

`ifdef SPI_PROG_READBACK_EN
  logic                  r_rd_capture, r_rd_first, w_rd_load;
  logic [DATA_WIDTH-1:0] r_rd_word, w_rd_word;

  function automatic logic [7:0] word_byte(input logic [DATA_WIDTH-1:0] w, input logic [3:0] idx);
    logic [DATA_WIDTH-1:0] s;
    s = w << {idx, 3'b000};
    return s[DATA_WIDTH-1 -: 8];
  endfunction

  // First word is loaded as soon as it arrives; later words wait for the next byte boundary.
  assign w_rd_load = (r_state == ST_READ) &&
                     ((r_rd_capture && r_rd_first) || (w_rx_valid && !r_rd_first));
  assign w_rd_word = (r_rd_capture && r_rd_first) ? mem_rd_data : r_rd_word;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^mem_rd_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_addr_acc    <= '0;
      r_byte_cnt    <= '0;
      r_wr_shift    <= '0;
      r_tx_load     <= 1'b0;
      r_tx_byte     <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_data <= '0;
      r_mem_rd_en   <= 1'b0;
      r_cpu_run     <= 1'b0;
      r_cmd_error   <= 1'b0;
`ifdef SPI_PROG_READBACK_EN
      r_rd_capture  <= 1'b0;
      r_rd_first    <= 1'b0;
      r_rd_word     <= '0;
`endif
    end else begin
      r_tx_load   <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_mem_rd_en <= 1'b0;
      if (r_mem_wr_en) r_ptr <= r_ptr + 1'b1;
`ifdef SPI_PROG_READBACK_EN
      r_rd_capture <= r_mem_rd_en;
`endif
      if (!w_cs_active) begin
        r_state    <= ST_IDLE;
        r_byte_cnt <= '0;
        r_wr_shift <= '0;
`ifdef SPI_PROG_READBACK_EN
        r_rd_first <= 1'b0;
`endif
      end else begin
        if (r_state == ST_IDLE) r_state <= ST_OPCODE;
        if (w_rx_valid) begin
          r_tx_load <= 1'b1;
          r_tx_byte <= 8'h00;
          case (r_state)
            ST_OPCODE: begin
              r_byte_cnt <= '0;
              case (w_rx_byte)
                OP_SET_ADDR: r_state <= ST_ADDR;
                OP_WRITE:    r_state <= ST_WRITE;
`ifdef SPI_PROG_READBACK_EN
                OP_READ: begin
                  r_state     <= ST_READ;
                  r_mem_rd_en <= 1'b1;
                  r_rd_first  <= 1'b1;
                end
`endif
                OP_ECHO:     r_state <= ST_ECHO;
                OP_RUN:      begin r_cpu_run <= 1'b1; r_state <= ST_DRAIN; end
                OP_HALT:     begin r_cpu_run <= 1'b0; r_state <= ST_DRAIN; end
                OP_STATUS: begin
                  r_tx_byte <= status_byte(r_cmd_error, r_cpu_run);
                  r_state   <= ST_STATUS;
                end
                default:     begin r_cmd_error <= 1'b1; r_state <= ST_DRAIN; end
              endcase
            end
            ST_ADDR: begin
              r_addr_acc <= w_addr_next;
              if (r_byte_cnt == LAST_ADDR_BYTE) begin
                r_ptr   <= w_addr_next;
                r_state <= ST_DRAIN;
              end else begin
                r_byte_cnt <= r_byte_cnt + 4'd1;
              end
            end
            ST_WRITE: begin
              r_wr_shift <= w_wr_next;
              if (r_byte_cnt == LAST_BYTE) begin
                r_mem_wr_en   <= 1'b1;
                r_mem_wr_data <= w_wr_next;
                r_byte_cnt    <= '0;
              end else begin
                r_byte_cnt <= r_byte_cnt + 4'd1;
              end
            end
            ST_ECHO:   r_tx_byte <= w_rx_byte;
            ST_STATUS: begin r_cmd_error <= 1'b0; r_state <= ST_DRAIN; end
            default:   ;
          endcase
        end
`ifdef SPI_PROG_READBACK_EN
        if (r_rd_capture) r_rd_word <= mem_rd_data;
        if (w_rd_load) begin
          r_tx_load  <= 1'b1;
          r_tx_byte  <= word_byte(w_rd_word, r_byte_cnt);
          r_rd_first <= 1'b0;
          if (r_byte_cnt == LAST_BYTE) begin
            r_byte_cnt  <= '0;
            r_mem_rd_en <= 1'b1;
            r_ptr       <= r_ptr + 1'b1;
          end else begin
            r_byte_cnt <= r_byte_cnt + 4'd1;
          end
        end
`endif
      end
    end
  end

  assign mem_addr    = r_ptr;
  assign mem_wr_en   = r_mem_wr_en;
  assign mem_wr_data = r_mem_wr_data;
  assign mem_rd_en   = r_mem_rd_en;
  assign cpu_rst_n   = r_cpu_run;
  assign busy        = w_cs_active;
  assign cmd_error   = r_cmd_error;

endmodule

// File: tb/tb_spi_prog_loader.sv
// Self-checking bench for spi_prog_loader: write scoreboard, table of control/echo
// transactions, and hand-written wrap, partial-word, readback and reset sequences.
module tb_spi_prog_loader;

  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int HALF = 8;

  logic          clk = 1'b0;
  logic          rst_n, sclk, cs, mosi, miso;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en, mem_rd_en, cpu_rst_n, busy, cmd_error;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] mem [0:15];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    string       name;
    int          n;
    logic [31:0] tx;
    logic [31:0] rx;
    logic        err;
    logic        run;
  } vec_t;

  wr_t        exp_wr_q[$];
  logic [7:0] exp_rx_q[$];
  vec_t       vecs[$];
  int         n_checks = 0, n_errors = 0, wr_count = 0, rd_count = 0;

  always #5 clk = ~clk;

  spi_prog_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .cs         (cs),
    .mosi       (mosi),
    .miso       (miso),
    .mem_addr   (mem_addr),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_data(mem_wr_data),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_data(mem_rd_data),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .cmd_error  (cmd_error)
  );

  initial for (int i = 0; i < 16; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_wr_en && mem_rd_en) check("wr_rd_exclusive", 64'd1, 64'd0);
    if (mem_rd_en) rd_count++;
    if (mem_wr_en) begin
      wr_t e;
      wr_count++;
      if (exp_wr_q.size() == 0) begin
        check("unexpected_write", {mem_addr, mem_wr_data}, 64'd0);
      end else begin
        e = exp_wr_q.pop_front();
        check("write_addr", 64'(mem_addr), 64'(e.addr));
        check("write_data", 64'(mem_wr_data), 64'(e.data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic xfer(input logic [7:0] tx, input bit chk, input logic [7:0] exp);
    logic [7:0] rx;
    logic [7:0] e;
    if (chk) exp_rx_q.push_back(exp);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = miso;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    if (chk) begin
      e = exp_rx_q.pop_front();
      check("miso_byte", 64'(rx), 64'(e));
    end
  endtask

  task automatic cs_begin();
    cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    cs   = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic set_addr(input logic [7:0] a);
    cs_begin();
    xfer(8'hC0, 1'b0, 8'h00);
    xfer(a, 1'b0, 8'h00);
    cs_end();
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [DW-1:0] w);
    exp_wr_q.push_back('{addr: a, data: w});
    for (int b = 3; b >= 0; b--) xfer(w[8*b +: 8], 1'b0, 8'h00);
  endtask

  initial begin
    int wc0;
    rst_n = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", 64'(miso), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_wr_en", 64'(mem_wr_en), 64'd0);
    check("rst_wr_data", 64'(mem_wr_data), 64'd0);
    check("rst_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cmd_error", 64'(cmd_error), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Burst write of two words starting at 5.
    wc0 = wr_count;
    cs_begin();
    check("busy_during_cs", 64'(busy), 64'd1);
    xfer(8'hC0, 1'b1, 8'h00);
    xfer(8'h05, 1'b0, 8'h00);
    cs_end();
    cs_begin();
    xfer(8'hC1, 1'b0, 8'h00);
    send_word(4'd5, 32'hDEADBEEF);
    send_word(4'd6, 32'h01020304);
    cs_end();
    check("t1_write_count", 64'(wr_count - wc0), 64'd2);
    check("t1_mem5", 64'(mem[5]), 64'hDEADBEEF);
    check("t1_mem6", 64'(mem[6]), 64'h01020304);
    check("t1_ptr", 64'(mem_addr), 64'd7);
    check("t1_busy_idle", 64'(busy), 64'd0);

    // Pointer wrap from 15 to 0.
    set_addr(8'h0F);
    check("t2_set_addr", 64'(mem_addr), 64'd15);
    cs_begin();
    xfer(8'hC1, 1'b0, 8'h00);
    send_word(4'd15, 32'h11223344);
    send_word(4'd0, 32'h55667788);
    cs_end();
    check("t2_mem15", 64'(mem[15]), 64'h11223344);
    check("t2_mem0", 64'(mem[0]), 64'h55667788);
    check("t2_ptr_wrapped", 64'(mem_addr), 64'd1);

    // Partial word discarded at cs rise, then a clean full word.
    wc0 = wr_count;
    cs_begin();
    xfer(8'hC1, 1'b0, 8'h00);
    xfer(8'hAA, 1'b0, 8'h00);
    xfer(8'hBB, 1'b0, 8'h00);
    xfer(8'hCC, 1'b0, 8'h00);
    cs_end();
    check("t3_no_partial_write", 64'(wr_count - wc0), 64'd0);
    set_addr(8'h03);
    cs_begin();
    xfer(8'hC1, 1'b0, 8'h00);
    send_word(4'd3, 32'hCAFEF00D);
    cs_end();
    check("t3_mem3", 64'(mem[3]), 64'hCAFEF00D);
    check("t3_write_count", 64'(wr_count - wc0), 64'd1);

    // Control and echo transactions: bytes MSB-aligned in tx/rx, n bytes each.
    vecs.push_back('{"echo",          4, 32'hC35AA500, 32'h00005AA5, 1'b0, 1'b0});
    vecs.push_back('{"illegal_c7",    2, 32'hC7330000, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{"status_err",    2, 32'hC6000000, 32'h00800000, 1'b0, 1'b0});
    vecs.push_back('{"run",           1, 32'hC4000000, 32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{"status_run",    2, 32'hC6000000, 32'h00400000, 1'b0, 1'b1});
    vecs.push_back('{"halt",          1, 32'hC5000000, 32'h00000000, 1'b0, 1'b0});
`ifndef SPI_PROG_READBACK_EN
    vecs.push_back('{"read_illegal",  2, 32'hC2000000, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{"status_clear",  2, 32'hC6000000, 32'h00800000, 1'b0, 1'b0});
`endif
    for (int v = 0; v < vecs.size(); v++) begin
      wc0 = wr_count;
      cs_begin();
      for (int j = 0; j < vecs[v].n; j++)
        xfer(vecs[v].tx[31-8*j -: 8], 1'b1, vecs[v].rx[31-8*j -: 8]);
      cs_end();
      check({vecs[v].name, "_cmd_error"}, 64'(cmd_error), 64'(vecs[v].err));
      check({vecs[v].name, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'(vecs[v].run));
      check({vecs[v].name, "_no_write"}, 64'(wr_count - wc0), 64'd0);
      check({vecs[v].name, "_miso_idle"}, 64'(miso), 64'd0);
    end

`ifdef SPI_PROG_READBACK_EN
    // Burst readback of mem[5], mem[6].
    begin
      logic [63:0] exp_bytes;
      exp_bytes = 64'hDEADBEEF01020304;
      wc0 = wr_count;
      set_addr(8'h05);
      cs_begin();
      xfer(8'hC2, 1'b1, 8'h00);
      for (int j = 0; j < 8; j++) xfer(8'hFF, 1'b1, exp_bytes[63-8*j -: 8]);
      cs_end();
      check("rb_no_write", 64'(wr_count - wc0), 64'd0);
      check("rb_cmd_error", 64'(cmd_error), 64'd0);
    end
`endif

    // Reset in the middle of a write word.
    cs_begin();
    xfer(8'hC4, 1'b0, 8'h00);
    cs_end();
    check("pre_reset_run", 64'(cpu_rst_n), 64'd1);
    wc0 = wr_count;
    cs_begin();
    xfer(8'hC1, 1'b0, 8'h00);
    xfer(8'h12, 1'b0, 8'h00);
    xfer(8'h34, 1'b0, 8'h00);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
    check("mid_rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_wr_en", 64'(mem_wr_en), 64'd0);
    check("mid_rst_wr_data", 64'(mem_wr_data), 64'd0);
    check("mid_rst_rd_en", 64'(mem_rd_en), 64'd0);
    check("mid_rst_miso", 64'(miso), 64'd0);
    check("mid_rst_cmd_error", 64'(cmd_error), 64'd0);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_rst_no_write", 64'(wr_count - wc0), 64'd0);
    check("post_rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);

    check("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
